// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A packed nibble is not a decimal digit when it exceeds nine.
    function automatic logic is_bad_digit(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD add/subtract cell.
// Subtraction adds the nines-complement of b_d; the caller supplies the +1
// through cin on the least-significant digit.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t a_d,
    input  bcd_digit_t b_d,
    input  logic       sub,
    input  logic       cin,
    output bcd_digit_t sum_d,
    output logic       cout
);

    bcd_digit_t b_eff;
    logic [4:0] s;

    // Binary digit sum, then +6 correction when the sum leaves the decimal range.
    always_comb begin
        b_eff = sub ? (BCD_MAX - b_d) : b_d;
        s     = {1'b0, a_d} + {1'b0, b_eff} + {4'd0, cin};
        if (s > {1'b0, BCD_MAX}) begin
            sum_d = s[3:0] + BCD_CORR;
            cout  = 1'b1;
        end else begin
            sum_d = s[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both 1; in_ready is 1 only in IDLE. A result is presented with
// out_valid=1 and held (result, carry, err stable) until a rising edge with
// out_ready=1 consumes it. Operations never overlap.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*DIGITS-1:0] result,
    output logic              carry,
    output logic              err,
    output state_t            dbg_state
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sub_q;
    logic             c_q;
    logic             err_q;
    logic             bad_in;
    bcd_digit_t       a_d;
    bcd_digit_t       b_d;
    bcd_digit_t       sum_d;
    logic             cout;

    assign dbg_state = state;

    // Flag any non-decimal nibble on the incoming operands.
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (is_bad_digit(a[4*i +: 4]) || is_bad_digit(b[4*i +: 4]))
                bad_in = 1'b1;
        end
    end

    // Select the operand digits addressed by the running index.
    always_comb begin
        a_d = a_q[4*int'(idx) +: 4];
        b_d = b_q[4*int'(idx) +: 4];
    end

    bcd_digit_addsub u_digit (
        .a_d   (a_d),
        .b_d   (b_d),
        .sub   (sub_q),
        .cin   (c_q),
        .sum_d (sum_d),
        .cout  (cout)
    );

    // Control FSM with registered outputs, digit index, operands and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
            c_q       <= 1'b0;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        sub_q    <= op_sub;
                        c_q      <= op_sub;
                        err_q    <= bad_in;
                        idx      <= '0;
                        result   <= '0;
                        carry    <= 1'b0;
                        err      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // An errored operation keeps its timing but writes zeros.
                    result[4*int'(idx) +: 4] <= err_q ? 4'd0 : sum_d;
                    c_q <= cout;
                    if (idx == LAST_IDX) begin
                        carry     <= err_q ? 1'b0 : cout;
                        err       <= err_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: a 4-digit and a 1-digit instance.
module tb_bcd_serial_addsub;
    import bcd_pkg::*;

    logic clk;
    logic rst_n;

    logic        in_valid4, in_ready4, op_sub4, out_valid4, out_ready4, carry4, err4;
    logic [15:0] a4, b4, result4;
    state_t      state4;

    logic        in_valid1, in_ready1, op_sub1, out_valid1, out_ready1, carry1, err1;
    logic [3:0]  a1, b1, result1;
    state_t      state1;

    int n_pass;
    int n_total;

    bcd_serial_addsub #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .op_sub(op_sub4), .a(a4), .b(b4), .out_valid(out_valid4),
        .out_ready(out_ready4), .result(result4), .carry(carry4), .err(err4),
        .dbg_state(state4)
    );

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_sub(op_sub1), .a(a1), .b(b1), .out_valid(out_valid1),
        .out_ready(out_ready1), .result(result1), .carry(carry1), .err(err1),
        .dbg_state(state1)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: present one op on the 4-digit DUT (called at a negedge, DUT idle),
    // return the number of rising edges from the accept edge to out_valid.
    task automatic drive4(input logic sub, input logic [15:0] av, input logic [15:0] bv,
                          output int lat);
        op_sub4 = sub; a4 = av; b4 = bv; in_valid4 = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); in_valid4 = 1'b0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic drive1(input logic sub, input logic [3:0] av, input logic [3:0] bv,
                          output int lat);
        op_sub1 = sub; a1 = av; b1 = bv; in_valid1 = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); in_valid1 = 1'b0;
        while (!out_valid1 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    // Let one edge pass with out_ready high so the result is consumed.
    task automatic pop;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid4 = 0; op_sub4 = 0; a4 = 0; b4 = 0; out_ready4 = 1;
        in_valid1 = 0; op_sub1 = 0; a1 = 0; b1 = 0; out_ready1 = 1;
        repeat (3) @(negedge clk);
        n_total++; if (in_ready4 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready4); else n_pass++;
        n_total++; if (out_valid4 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid4); else n_pass++;
        n_total++; if (result4 !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result4); else n_pass++;
        n_total++; if ({carry4, err4} !== 2'b00) $display("FAIL reset_carry_err: got %b want 00", {carry4, err4}); else n_pass++;
        n_total++; if (state4 !== IDLE) $display("FAIL reset_state: got %0d want %0d", state4, IDLE); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        int lat;
        drive4(1'b0, 16'h1234, 16'h8766, lat);
        n_total++; if (lat !== 5) $display("FAIL add_latency: got %0d want 5", lat); else n_pass++;
        n_total++; if (result4 !== 16'h0000) $display("FAIL add_result: got %h want 0000", result4); else n_pass++;
        n_total++; if (carry4 !== 1'b1) $display("FAIL add_carry: got %b want 1", carry4); else n_pass++;
        n_total++; if (err4 !== 1'b0) $display("FAIL add_err: got %b want 0", err4); else n_pass++;
        n_total++; if (in_ready4 !== 1'b0) $display("FAIL add_in_ready_done: got %b want 0", in_ready4); else n_pass++;
        pop();
        n_total++; if ({in_ready4, out_valid4} !== 2'b10) $display("FAIL add_release: got %b want 10", {in_ready4, out_valid4}); else n_pass++;
    endtask

    task automatic test_sub;
        int lat;
        drive4(1'b1, 16'h0500, 16'h0123, lat);
        n_total++; if (result4 !== 16'h0377) $display("FAIL sub_pos_result: got %h want 0377", result4); else n_pass++;
        n_total++; if (carry4 !== 1'b1) $display("FAIL sub_pos_carry: got %b want 1", carry4); else n_pass++;
        pop();
        drive4(1'b1, 16'h0123, 16'h0500, lat);
        n_total++; if (lat !== 5) $display("FAIL sub_neg_latency: got %0d want 5", lat); else n_pass++;
        n_total++; if (result4 !== 16'h9623) $display("FAIL sub_neg_result: got %h want 9623", result4); else n_pass++;
        n_total++; if (carry4 !== 1'b0) $display("FAIL sub_neg_carry: got %b want 0", carry4); else n_pass++;
        pop();
        drive4(1'b0, 16'h4095, 16'h0517, lat);
        n_total++; if ({carry4, result4} !== {1'b0, 16'h4612}) $display("FAIL add_mixed: got %b %h want 0 4612", carry4, result4); else n_pass++;
        pop();
    endtask

    task automatic test_err;
        int lat;
        drive4(1'b0, 16'h00A1, 16'h0001, lat);
        n_total++; if (lat !== 5) $display("FAIL err_latency: got %0d want 5", lat); else n_pass++;
        n_total++; if (err4 !== 1'b1) $display("FAIL err_flag: got %b want 1", err4); else n_pass++;
        n_total++; if (result4 !== 16'h0000) $display("FAIL err_result: got %h want 0000", result4); else n_pass++;
        n_total++; if (carry4 !== 1'b0) $display("FAIL err_carry: got %b want 0", carry4); else n_pass++;
        pop();
        drive4(1'b0, 16'h0001, 16'h0001, lat);
        n_total++; if ({err4, result4} !== {1'b0, 16'h0002}) $display("FAIL err_cleared: got %b %h want 0 0002", err4, result4); else n_pass++;
        pop();
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        out_ready4 = 1'b0;
        drive4(1'b0, 16'h9999, 16'h0001, lat);
        n_total++; if ({carry4, result4} !== {1'b1, 16'h0000}) $display("FAIL bp_first: got %b %h want 1 0000", carry4, result4); else n_pass++;
        // Offer a different op while stalled; it must be ignored.
        op_sub4 = 1'b1; a4 = 16'h1111; b4 = 16'h0001; in_valid4 = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || result4 !== 16'h0000 || carry4 !== 1'b1 || err4 !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        pop();
        n_total++; if ({in_ready4, out_valid4} !== 2'b10) $display("FAIL bp_release: got %b want 10", {in_ready4, out_valid4}); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int lat;
        op_sub4 = 1'b0; a4 = 16'h1111; b4 = 16'h2222; in_valid4 = 1'b1;
        @(posedge clk); @(negedge clk); in_valid4 = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        n_total++; if (state4 !== RUN) $display("FAIL mid_state_run: got %0d want %0d", state4, RUN); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({in_ready4, out_valid4} !== 2'b10) $display("FAIL mid_reset_hs: got %b want 10", {in_ready4, out_valid4}); else n_pass++;
        n_total++; if (result4 !== 16'h0000) $display("FAIL mid_reset_result: got %h want 0000", result4); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        drive4(1'b0, 16'h0005, 16'h0005, lat);
        n_total++; if (lat !== 5) $display("FAIL post_reset_latency: got %0d want 5", lat); else n_pass++;
        n_total++; if ({carry4, result4} !== {1'b0, 16'h0010}) $display("FAIL post_reset_op: got %b %h want 0 0010", carry4, result4); else n_pass++;
        pop();
    endtask

    task automatic test_single_digit;
        int lat;
        drive1(1'b0, 4'h9, 4'h9, lat);
        n_total++; if (lat !== 2) $display("FAIL d1_latency: got %0d want 2", lat); else n_pass++;
        n_total++; if ({carry1, result1} !== {1'b1, 4'h8}) $display("FAIL d1_9p9: got %b %h want 1 8", carry1, result1); else n_pass++;
        pop();
        drive1(1'b0, 4'hB, 4'h1, lat);
        n_total++; if ({err1, carry1, result1} !== {2'b10, 4'h0}) $display("FAIL d1_err: got %b%b %h want 10 0", err1, carry1, result1); else n_pass++;
        pop();
    endtask

    task automatic test_back_to_back;
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vs [3];
        logic [4:0] exp_cr [3];
        int lat;
        va = '{4'h5, 4'h3, 4'h7};
        vb = '{4'h4, 4'h7, 4'h2};
        vs = '{1'b0, 1'b1, 1'b1};
        exp_cr = '{5'h09, 5'h06, 5'h15};
        for (int i = 0; i < 3; i++) begin
            n_total++; if (in_ready1 !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready1); else n_pass++;
            drive1(vs[i], va[i], vb[i], lat);
            n_total++; if (lat !== 2) $display("FAIL b2b_latency_%0d: got %0d want 2", i, lat); else n_pass++;
            n_total++; if ({carry1, result1} !== exp_cr[i]) $display("FAIL b2b_result_%0d: got %b %h want %h", i, carry1, result1, exp_cr[i]); else n_pass++;
            pop();
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_add();
        test_sub();
        test_err();
        test_backpressure();
        test_reset_mid_run();
        test_single_digit();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
